// File: rtl/oifs_tx_arb.sv
// rtl/oifs_tx_arb.sv - round-robin byte-stream arbiter in front of the oifs serializer
//
// Shares one serializer transmit channel between N_REQ byte producers. One
// requester is granted at a time and its byte plus FT channel bit are passed
// straight through to the serializer over a valid/ready handshake. A grant
// ends after MAX_BURST bytes or when the requester drops valid; the next
// search starts one past the requester just served.
//
// Optional stall watchdog: define OIFS_TX_ARB_STALL_EN. A grant that waits on
// the serializer for TIMEOUT cycles is released and o_stall latches high
// until reset. Without the macro o_stall is tied low and grants wait forever.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_req_valid/data/dest per-requester byte stream (data k at [8k+7:8k])
//   o_req_ready          per-requester accept
//   o_tx_valid/data/dest byte toward serializer, i_tx_ready its accept
//   o_grant, o_busy      one-hot current grant, grant active
//   o_stall              sticky stall flag

module oifs_tx_arb #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 1000000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [8*N_REQ-1:0] i_req_data,
  input  logic [N_REQ-1:0]   i_req_dest,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic               o_tx_valid,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_dest,
  input  logic               i_tx_ready,
  output logic [N_REQ-1:0]   o_grant,
  output logic               o_busy,
  output logic               o_stall
);

  localparam int IW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  if (N_REQ < 2 || N_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 255 || TIMEOUT < 1) begin : g_bad_param
    $error("oifs_tx_arb: parameter out of range");
  end

  typedef enum logic {IDLE, GRANT} state_e;

  state_e           state_q;
  logic [N_REQ-1:0] grant_q;
  logic [IW-1:0]    gidx_q;
  logic [IW-1:0]    ptr_q;
  logic [BW-1:0]    burst_q;

  logic             arb_found;
  logic [IW-1:0]    arb_idx;
  logic [IW:0]      sum;
  logic [IW-1:0]    cand;
  logic [IW-1:0]    next_ptr;
  logic             in_grant;
  logic             xfer;
  logic             burst_last;
  logic             timeout_hit;
  logic [IW+2:0]    data_base;

  // First valid requester at or after the round-robin pointer, wrapping mod N_REQ.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(i);
      if (sum >= (IW+1)'(N_REQ)) begin
        sum = sum - (IW+1)'(N_REQ);
      end
      cand = sum[IW-1:0];
      if (!arb_found && i_req_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  assign next_ptr   = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + IW'(1);
  assign xfer       = (state_q == GRANT) && i_req_valid[gidx_q] && i_tx_ready;
  assign burst_last = (burst_q == BW'(MAX_BURST - 1));

  // Handshake outputs are masked during reset so nothing moves in the reset cycle.
  assign in_grant    = (state_q == GRANT) && !i_rst;
  assign data_base   = {gidx_q, 3'b000};
  assign o_tx_valid  = in_grant && i_req_valid[gidx_q];
  assign o_tx_data   = i_req_data[data_base +: 8];
  assign o_tx_dest   = i_req_dest[gidx_q];
  assign o_req_ready = (in_grant && i_tx_ready) ? grant_q : '0;
  assign o_grant     = grant_q;
  assign o_busy      = (state_q == GRANT);

`ifdef OIFS_TX_ARB_STALL_EN
  localparam int SW = $clog2(TIMEOUT + 1);

  logic [SW-1:0] stall_cnt_q;
  logic          stall_q;
  logic          stalled;

  assign stalled     = (state_q == GRANT) && i_req_valid[gidx_q] && !i_tx_ready;
  assign timeout_hit = stalled && (stall_cnt_q == SW'(TIMEOUT - 1));
  assign o_stall     = stall_q;

  // Counts consecutive blocked cycles of the current grant; any other cycle clears it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt_q <= '0;
      stall_q     <= 1'b0;
    end else begin
      if (stalled && !timeout_hit) begin
        stall_cnt_q <= stall_cnt_q + SW'(1);
      end else begin
        stall_cnt_q <= '0;
      end
      if (timeout_hit) begin
        stall_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign o_stall     = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_found) begin
            state_q <= GRANT;
            grant_q <= {{(N_REQ-1){1'b0}}, 1'b1} << arb_idx;
            gidx_q  <= arb_idx;
            burst_q <= '0;
          end
        end
        GRANT: begin
          // Release on valid drop, stall timeout, or the MAX_BURST-th byte.
          if (!i_req_valid[gidx_q] || timeout_hit || (xfer && burst_last)) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= next_ptr;
            burst_q <= '0;
          end else if (xfer) begin
            burst_q <= burst_q + BW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oifs_tx_arb.sv
// tb/tb_oifs_tx_arb.sv - self-checking scoreboard bench for oifs_tx_arb
module tb_oifs_tx_arb;

  localparam int N  = 4;
  localparam int MB = 16;
  localparam int TO = 50;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic [N-1:0]   i_req_valid;
  logic [8*N-1:0] i_req_data;
  logic [N-1:0]   i_req_dest;
  logic [N-1:0]   o_req_ready;
  logic           o_tx_valid;
  logic [7:0]     o_tx_data;
  logic           o_tx_dest;
  logic           i_tx_ready;
  logic [N-1:0]   o_grant;
  logic           o_busy;
  logic           o_stall;

  always #5 i_clk = ~i_clk;

  oifs_tx_arb #(.N_REQ(N), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .i_req_data(i_req_data), .i_req_dest(i_req_dest),
    .o_req_ready(o_req_ready),
    .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .o_tx_dest(o_tx_dest),
    .i_tx_ready(i_tx_ready),
    .o_grant(o_grant), .o_busy(o_busy), .o_stall(o_stall)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Per-requester byte sources {dest, data}
  logic [8:0]  mem [N][64];
  int          head [N];
  int          tail [N];
  logic [N-1:0] fire;
  // Scoreboard entries {grant one-hot, dest, data}
  logic [12:0] sb_q [$];
  logic [3:0]  trace_q [$];
  logic [3:0]  run_v [$];
  int          run_l [$];

  always @(negedge i_clk) begin
    logic [12:0] exp_e;
    fire = i_rst ? '0 : (i_req_valid & o_req_ready);
    if (!i_rst && o_tx_valid && i_tx_ready) begin
      chk_cnt++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_unexpected: got grant=%b dest=%b data=%h, required no transfer", o_grant, o_tx_dest, o_tx_data);
      end else begin
        exp_e = sb_q.pop_front();
        if ({o_grant, o_tx_dest, o_tx_data} !== exp_e)
          $display("FAIL sb_transfer: got grant=%b dest=%b data=%h, required grant=%b dest=%b data=%h",
                   o_grant, o_tx_dest, o_tx_data, exp_e[12:9], exp_e[8], exp_e[7:0]);
        else pass_cnt++;
      end
    end
  end

  function automatic bit src_empty();
    for (int k = 0; k < N; k++) if (head[k] < tail[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      int h;
      h = (head[k] < tail[k]) ? head[k] : 0;
      i_req_valid[k]      = (head[k] < tail[k]);
      i_req_data[8*k +: 8] = mem[k][h][7:0];
      i_req_dest[k]       = mem[k][h][8];
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    for (int k = 0; k < N; k++) if (fire[k] && head[k] < tail[k]) head[k]++;
    fire = '0;
    drive();
  endtask

  task automatic push_src(input int k, input logic [7:0] d, input logic dst, input bit to_sb);
    mem[k][tail[k]] = {dst, d};
    tail[k]++;
    if (to_sb) sb_q.push_back({4'(1 << k), dst, d});
  endtask

  task automatic run_trace(input int limit, output int n);
    trace_q.delete();
    n = 0;
    while (n < limit) begin
      tick();
      @(negedge i_clk);
      trace_q.push_back(o_grant);
      n++;
      if (src_empty() && !o_busy) break;
    end
  endtask

  task automatic build_runs();
    bit started;
    started = 1'b0;
    run_v.delete();
    run_l.delete();
    foreach (trace_q[i]) begin
      if (!started && trace_q[i] == 4'b0) continue;
      started = 1'b1;
      if (run_v.size() > 0 && run_v[run_v.size()-1] == trace_q[i]) run_l[run_l.size()-1]++;
      else begin
        run_v.push_back(trace_q[i]);
        run_l.push_back(1);
      end
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    for (int k = 0; k < N; k++) push_src(k, 8'(8'h10 + k), k[0], 1'b1);
    drive();
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk_cnt++;
      if ({o_grant, o_tx_valid, o_req_ready, o_busy, o_stall} !== '0)
        $display("FAIL reset_hold: got grant=%b tx_valid=%b ready=%b busy=%b stall=%b, required all 0",
                 o_grant, o_tx_valid, o_req_ready, o_busy, o_stall);
      else pass_cnt++;
    end
    tick();
    i_rst = 1'b0;
    @(negedge i_clk);
    chk_cnt++;
    if (o_grant !== 4'b0000) $display("FAIL reset_arb_latency: got grant=%b, required 0000", o_grant);
    else pass_cnt++;
    tick();
    @(negedge i_clk);
    chk_cnt++;
    if (o_grant !== 4'b0001) $display("FAIL reset_first_grant: got grant=%b, required 0001", o_grant);
    else pass_cnt++;
    begin
      int n;
      run_trace(200, n);
      chk_cnt++;
      if (n >= 200 || sb_q.size() != 0) $display("FAIL reset_drain: got cycles=%0d left=%0d, required <200 and 0", n, sb_q.size());
      else pass_cnt++;
    end
  endtask

  task automatic test_all_burst();
    logic [3:0] ev [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    int         el [9] = '{16, 1, 16, 1, 16, 1, 16, 1, 16};
    int n;
    for (int k = 0; k < N; k++)
      for (int i = 0; i < MB; i++) push_src(k, 8'(k*64 + i), 1'(i ^ k), 1'b1);
    for (int i = MB; i < 2*MB; i++) push_src(0, 8'(i), 1'(i), 1'b1);
    run_trace(300, n);
    chk_cnt++;
    if (n >= 300 || sb_q.size() != 0) $display("FAIL burst_drain: got cycles=%0d left=%0d, required <300 and 0", n, sb_q.size());
    else pass_cnt++;
    build_runs();
    for (int i = 0; i < 9; i++) begin
      chk_cnt++;
      if (i >= run_v.size()) $display("FAIL burst_run%0d: got none, required grant=%b x%0d", i, ev[i], el[i]);
      else if (run_v[i] !== ev[i] || run_l[i] != el[i])
        $display("FAIL burst_run%0d: got grant=%b x%0d, required grant=%b x%0d", i, run_v[i], run_l[i], ev[i], el[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] ev [3] = '{4'b0001, 4'b0000, 4'b0001};
    int         el [3] = '{26, 1, 3};
    int n, low;
    n = 0; low = 0;
    for (int i = 0; i < 18; i++) push_src(0, (i == 5) ? 8'hA5 : 8'(8'h30 + i), 1'b0, 1'b1);
    trace_q.delete();
    while (n < 300) begin
      tick();
      if (o_busy && head[0] < tail[0] && mem[0][head[0]][7:0] == 8'hA5 && low < 10) begin
        i_tx_ready = 1'b0;
        low++;
      end else i_tx_ready = 1'b1;
      @(negedge i_clk);
      trace_q.push_back(o_grant);
      if (!i_tx_ready) begin
        chk_cnt++;
        if ({o_grant, o_tx_valid, o_tx_data} !== {4'b0001, 1'b1, 8'hA5})
          $display("FAIL bp_hold: got grant=%b valid=%b data=%h, required 0001 1 a5", o_grant, o_tx_valid, o_tx_data);
        else pass_cnt++;
      end
      n++;
      if (src_empty() && !o_busy) break;
    end
    i_tx_ready = 1'b1;
    chk_cnt++;
    if (n >= 300 || low != 10 || sb_q.size() != 0)
      $display("FAIL bp_drain: got cycles=%0d low=%0d left=%0d, required <300 10 0", n, low, sb_q.size());
    else pass_cnt++;
    build_runs();
    for (int i = 0; i < 3; i++) begin
      chk_cnt++;
      if (i >= run_v.size()) $display("FAIL bp_run%0d: got none, required grant=%b x%0d", i, ev[i], el[i]);
      else if (run_v[i] !== ev[i] || run_l[i] != el[i])
        $display("FAIL bp_run%0d: got grant=%b x%0d, required grant=%b x%0d", i, run_v[i], run_l[i], ev[i], el[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_single();
    int n;
    for (int i = 0; i < 5; i++) push_src(2, 8'(i), 1'b1, 1'b1);
    run_trace(100, n);
    build_runs();
    chk_cnt++;
    if (run_v.size() < 1 || run_v[0] !== 4'b0100 || run_l[0] != 6 || sb_q.size() != 0)
      $display("FAIL single_stream: got grant=%b x%0d left=%0d, required 0100 x6 left 0",
               (run_v.size() > 0) ? run_v[0] : 4'bx, (run_l.size() > 0) ? run_l[0] : -1, sb_q.size());
    else pass_cnt++;
    // Pointer now 3: requester 3 beats requester 0.
    push_src(3, 8'h3C, 1'b1, 1'b1);
    push_src(0, 8'h0C, 1'b0, 1'b1);
    run_trace(100, n);
    chk_cnt++;
    if (n >= 100 || sb_q.size() != 0) $display("FAIL single_next_ptr: got cycles=%0d left=%0d, required <100 0", n, sb_q.size());
    else pass_cnt++;
  endtask

  task automatic test_rr_order();
    int n;
    push_src(1, 8'h11, 1'b0, 1'b1);
    run_trace(100, n);
    // Pointer now 2: requester 3 before requester 1.
    push_src(1, 8'h21, 1'b1, 1'b0);
    push_src(1, 8'h22, 1'b0, 1'b0);
    push_src(3, 8'h23, 1'b0, 1'b1);
    push_src(3, 8'h24, 1'b1, 1'b1);
    sb_q.push_back({4'b0010, 1'b1, 8'h21});
    sb_q.push_back({4'b0010, 1'b0, 8'h22});
    run_trace(100, n);
    chk_cnt++;
    if (n >= 100 || sb_q.size() != 0) $display("FAIL rr_drain: got cycles=%0d left=%0d, required <100 0", n, sb_q.size());
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int g;
    g = 0;
    push_src(1, 8'h5A, 1'b0, 1'b0);
    i_tx_ready = 1'b0;
`ifdef OIFS_TX_ARB_STALL_EN
    for (int i = 0; i < 200; i++) begin
      tick();
      @(negedge i_clk);
      if (o_stall) break;
      if (o_grant == 4'b0010) g++;
    end
    chk_cnt++;
    if (g != TO || o_stall !== 1'b1 || o_grant !== 4'b0000)
      $display("FAIL stall_timeout: got grant_cycles=%0d stall=%b grant=%b, required %0d 1 0000", g, o_stall, o_grant, TO);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) tick();
    @(negedge i_clk);
    chk_cnt++;
    if (o_stall !== 1'b1) $display("FAIL stall_sticky: got %b, required 1", o_stall);
    else pass_cnt++;
    head[1] = tail[1];
    i_rst = 1'b1;
    tick();
    @(negedge i_clk);
    chk_cnt++;
    if (o_stall !== 1'b0 || o_grant !== 4'b0000) $display("FAIL stall_clear: got stall=%b grant=%b, required 0 0000", o_stall, o_grant);
    else pass_cnt++;
    i_rst = 1'b0;
    i_tx_ready = 1'b1;
`else
    for (int i = 0; i < 60; i++) begin
      tick();
      @(negedge i_clk);
      if (o_grant == 4'b0010) g++;
    end
    chk_cnt++;
    if (g != 59 || o_stall !== 1'b0 || o_grant !== 4'b0010)
      $display("FAIL stall_hold: got grant_cycles=%0d stall=%b grant=%b, required 59 0 0010", g, o_stall, o_grant);
    else pass_cnt++;
    sb_q.push_back({4'b0010, 1'b0, 8'h5A});
    i_tx_ready = 1'b1;
    begin
      int n;
      run_trace(100, n);
      chk_cnt++;
      if (n >= 100 || sb_q.size() != 0) $display("FAIL stall_release: got cycles=%0d left=%0d, required <100 0", n, sb_q.size());
      else pass_cnt++;
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      head[k] = 0;
      tail[k] = 0;
      for (int i = 0; i < 64; i++) mem[k][i] = '0;
    end
    fire        = '0;
    i_tx_ready  = 1'b1;
    i_req_valid = '0;
    i_req_data  = '0;
    i_req_dest  = '0;
    test_reset();
    test_all_burst();
    test_backpressure();
    test_single();
    test_rr_order();
    test_stall();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
